// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary input path.
// State encoding, digit and value limits, and the invalid-digit check.
package bcd_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      FIM      = 2'd2
   } estado_t;

   localparam logic [3:0]  DIGITO_MAX     = 4'd9;
   localparam logic [16:0] VALOR_MAX      = 17'd65535;
   localparam int          NUM_DIGITOS    = 5;
   localparam logic [15:0] VALOR_SATURADO = 16'hFFFF;
   localparam logic [2:0]  ULTIMO_PASSO   = 3'(NUM_DIGITOS - 1);

   // True when any of the packed nibbles is not a decimal digit.
   function automatic logic algum_invalido(input logic [19:0] digitos);
      logic inv;
      inv = 1'b0;
      for (int i = 0; i < NUM_DIGITOS; i++) begin
         if (digitos[4*i +: 4] > DIGITO_MAX) begin
            inv = 1'b1;
         end else begin
            inv = inv;
         end
      end
      return inv;
   endfunction

endpackage

// File: rtl/bcd_para_binario_passo_mul10.sv
// One fold step: acc*10 + digit.
// The multiply is done with two shifts so no multiplier is inferred.
module passo_mul10 (
   input  logic [16:0] acc,
   input  logic [3:0]  digito,
   output logic [16:0] resultado
);

   logic [16:0] acc_x8_s;
   logic [16:0] acc_x2_s;

   assign acc_x8_s  = acc << 3;
   assign acc_x2_s  = acc << 1;
   assign resultado = acc_x8_s + acc_x2_s + {13'd0, digito};

endmodule

// File: rtl/bcd_para_binario.sv
// Five-digit packed BCD to 16-bit binary converter, one digit per clock.
// Out-of-range digits or results above 65535 saturate to FFFF with erro set.
module bcd_para_binario
   import bcd_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        iniciar,
   input  logic [3:0]  dezenademilhar,
   input  logic [3:0]  milhar,
   input  logic [3:0]  centena,
   input  logic [3:0]  dezena,
   input  logic [3:0]  unidade,
   output logic [15:0] dado,
   output logic        pronto,
   output logic        ocupado,
   output logic        erro
);

   estado_t     estado_r;
   estado_t     prox_estado_s;
   logic [19:0] digitos_s;
   logic [19:0] desloc_r;
   logic [16:0] acc_r;
   logic [16:0] acc_prox_s;
   logic [2:0]  cont_r;
   logic        invalido_r;
   logic [15:0] dado_r;
   logic        erro_r;
   logic        ultimo_passo_s;

   assign digitos_s      = {dezenademilhar, milhar, centena, dezena, unidade};
   assign ultimo_passo_s = (cont_r == ULTIMO_PASSO);

   passo_mul10 u_passo (
      .acc       (acc_r),
      .digito    (desloc_r[19:16]),
      .resultado (acc_prox_s)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_r <= OCIOSO;
      end else begin
         estado_r <= prox_estado_s;
      end
   end

   // Next-state logic; iniciar is only looked at while idle.
   always_comb begin
      prox_estado_s = estado_r;
      case (estado_r)
         OCIOSO:   prox_estado_s = iniciar ? CONVERTE : OCIOSO;
         CONVERTE: prox_estado_s = ultimo_passo_s ? FIM : CONVERTE;
         FIM:      prox_estado_s = OCIOSO;
         default:  prox_estado_s = OCIOSO;
      endcase
   end

   // Status outputs decoded from the state register.
   always_comb begin
      pronto  = 1'b0;
      ocupado = 1'b0;
      case (estado_r)
         OCIOSO:   begin pronto = 1'b0; ocupado = 1'b0; end
         CONVERTE: begin pronto = 1'b0; ocupado = 1'b1; end
         FIM:      begin pronto = 1'b1; ocupado = 1'b1; end
         default:  begin pronto = 1'b0; ocupado = 1'b0; end
      endcase
   end

   // Datapath: capture, fold one digit per step, load result on the last step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         desloc_r   <= 20'd0;
         acc_r      <= 17'd0;
         cont_r     <= 3'd0;
         invalido_r <= 1'b0;
         dado_r     <= 16'd0;
         erro_r     <= 1'b0;
      end else begin
         case (estado_r)
            OCIOSO: begin
               if (iniciar) begin
                  desloc_r   <= digitos_s;
                  acc_r      <= 17'd0;
                  cont_r     <= 3'd0;
                  invalido_r <= algum_invalido(digitos_s);
               end
            end
            CONVERTE: begin
               acc_r    <= acc_prox_s;
               desloc_r <= {desloc_r[15:0], 4'd0};
               cont_r   <= cont_r + 3'd1;
               if (ultimo_passo_s) begin
                  if (invalido_r || (acc_prox_s > VALOR_MAX)) begin
                     dado_r <= VALOR_SATURADO;
                     erro_r <= 1'b1;
                  end else begin
                     dado_r <= acc_prox_s[15:0];
                     erro_r <= 1'b0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dado = dado_r;
   assign erro = erro_r;

endmodule
